// File: rtl/mrv32_ctrl.sv
// -----------------------------------------------------------------------------
// mrv32_ctrl
//
// Multi-cycle sequencer for the MRV32 core. Owns the program counter and the
// instruction register and walks every instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB. It handshakes with the instruction
// and data memories, strobes the datapath, and drops into a sticky TRAP state
// on unsupported instructions or misaligned JAL targets.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_req          : fetch request, high in FETCH
//   imem_addr         : fetch address (always equal to pc)
//   imem_rvalid       : fetch data valid (same cycle as imem_req or later)
//   imem_rdata        : fetched instruction word
//   ir                : instruction register, feeds the decoder
//   dec_mem_ren       : decoder says load
//   dec_mem_wen       : decoder says store
//   dec_reg_wen       : decoder says the instruction writes rd
//   dec_is_jal        : decoder says JAL
//   dec_unsupported   : decoder cannot handle ir
//   dec_imm           : decoder immediate for ir
//   ex_en             : one-cycle EXEC strobe, datapath latches ALU result
//   dmem_req          : data access request, high in MEM
//   dmem_ready        : data access complete
//   rf_wen            : register-file write strobe (WB only)
//   wb_sel            : writeback mux select, 0 ALU / 1 load / 2 PC+4
//   pc                : address of the current instruction
//   trap              : sticky halt indicator
//   trap_pc           : pc of the faulting instruction
//   instret           : retired-instruction counter (wraps at 2^32)
// -----------------------------------------------------------------------------
module mrv32_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decoder
  output logic [31:0] ir,
  input  logic        dec_mem_ren,
  input  logic        dec_mem_wen,
  input  logic        dec_reg_wen,
  input  logic        dec_is_jal,
  input  logic        dec_unsupported,
  input  logic [31:0] dec_imm,
  // datapath / data memory
  output logic        ex_en,
  output logic        dmem_req,
  input  logic        dmem_ready,
  output logic        rf_wen,
  output logic [1:0]  wb_sel,
  // architectural status
  output logic [31:0] pc,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t state, state_next;

  // Decoder flags captured at DECODE. The decoder output is stable while ir
  // holds, so capturing it once is equivalent to sampling it live, and it
  // keeps rf_wen and wb_sel free of combinational paths from the inputs.
  logic        is_load;
  logic        is_store;
  logic        reg_wen_q;
  logic        is_jal_q;
  logic [31:0] imm_q;

  logic        jal_misaligned;
  logic [1:0]  jal_target_lo;
  logic        decode_fault;
  logic        retire;
  logic [31:0] pc_next_seq;

  // ---------------------------------------------------------------------------
  // Decode-time fault detection. Only the two low bits of pc + imm decide
  // alignment, and carries only propagate upward, so a 2-bit add suffices.
  // ---------------------------------------------------------------------------
  assign jal_target_lo  = pc[1:0] + dec_imm[1:0];
  assign jal_misaligned = dec_is_jal & (|jal_target_lo);
  assign decode_fault   = dec_unsupported | jal_misaligned;

  // An instruction retires when it leaves WB, or when a store finishes in MEM.
  assign retire = (state == S_WB) |
                  ((state == S_MEM) & dmem_ready & is_store);

  // Sequential successor; JAL redirects. Both wrap modulo 2^32 naturally.
  assign pc_next_seq = is_jal_q ? (pc + imm_q) : (pc + 32'd4);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order the processes execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next is given a default before the case so that every path
  // assigns it and no latch is inferred for the hold cases.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (imem_rvalid) state_next = S_DECODE;
      S_DECODE: state_next = decode_fault ? S_TRAP : S_EXEC;
      S_EXEC:   state_next = (is_load | is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ready) state_next = is_store ? S_FETCH : S_WB;
      end
      S_WB:     state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_TRAP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Requests and strobes decode from registered state only.
  // ---------------------------------------------------------------------------
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign ex_en     = (state == S_EXEC);
  assign dmem_req  = (state == S_MEM);
  assign rf_wen    = (state == S_WB) & reg_wen_q;
  assign trap      = (state == S_TRAP);

  // The writeback select is presented from EXEC onward so the datapath mux
  // has settled well before the WB strobe; it reads 0 everywhere else.
  always_comb begin
    wb_sel = WB_ALU;
    if ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) begin
      if (is_jal_q)     wb_sel = WB_LINK;
      else if (is_load) wb_sel = WB_LOAD;
      else              wb_sel = WB_ALU;
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural registers. In TRAP none of the enables below can fire, so
  // pc, ir and instret stay frozen until reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ir      <= NOP_INSTR;
      instret <= 32'd0;
      trap_pc <= 32'd0;
    end else begin
      if ((state == S_FETCH) && imem_rvalid) begin
        ir <= imem_rdata;
      end
      if ((state == S_DECODE) && decode_fault) begin
        trap_pc <= pc;
      end
      if (retire) begin
        pc      <= pc_next_seq;
        instret <= instret + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Captured decoder flags. A store wins over a load if the decoder ever
  // raises both, so the access always completes through the store path.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_load   <= 1'b0;
      is_store  <= 1'b0;
      reg_wen_q <= 1'b0;
      is_jal_q  <= 1'b0;
      imm_q     <= 32'd0;
    end else if (state == S_DECODE) begin
      is_load   <= dec_mem_ren & ~dec_mem_wen;
      is_store  <= dec_mem_wen;
      reg_wen_q <= dec_reg_wen;
      is_jal_q  <= dec_is_jal;
      imm_q     <= dec_imm;
    end
  end

endmodule
